// File: rtl/aes_decrypt_ctrl.sv
// rtl/aes_decrypt_ctrl.sv - iterative AES-128 inverse cipher, one round per clock.
// Optional key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_ctrl #(
  parameter logic [127:0] DOUT_RST = 128'h0
) (
  input  logic         clk,
  input  logic         g_rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic [127:0] data_out,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] blk;
  logic [127:0] rk [0:10];
  logic         accept;
  logic         hit;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, tmp, n0, n1, n2, n3;
    w3  = k[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0  = k[127:96] ^ tmp;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows then InvSubBytes; byte n sits at row n%4, column n/4
  function automatic logic [127:0] inv_core(input logic [127:0] s);
    logic [127:0] t;
    int src;
    for (int n = 0; n < 16; n++) begin
      src = 4 * (((n / 4) + 4 - (n % 4)) % 4) + (n % 4);
      t[127 - 8*n -: 8] = inv_sbox(s[127 - 8*src -: 8]);
    end
    return t;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      t[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      t[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      t[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      t[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return t;
  endfunction

`ifdef AES_DEC_KEY_CACHE_EN
  logic key_valid;
  assign hit = key_valid && (key_in == rk[0]);

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst)                                key_valid <= 1'b0;
    else if (accept && !hit)                  key_valid <= 1'b0;
    else if (state == KEYEXP && cnt == 4'd10) key_valid <= 1'b1;
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // ready drops during the done cycle so a start there is ignored
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready  = !done;
        accept = start && !done;
        if (accept) state_nxt = hit ? INIT : KEYEXP;
      end
      KEYEXP:  if (cnt == 4'd10) state_nxt = INIT;
      INIT:    state_nxt = ROUND;
      ROUND:   if (cnt == 4'd1) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      cnt      <= 4'd0;
      blk      <= 128'h0;
      data_out <= DOUT_RST;
      done     <= 1'b0;
    end else begin
      done <= (state == FINAL);
      case (state)
        IDLE: if (accept) begin
          blk <= data_in;
          cnt <= 4'd1;
        end
        KEYEXP: cnt <= cnt + 4'd1;
        INIT: begin
          blk <= blk ^ rk[10];
          cnt <= 4'd9;
        end
        ROUND: begin
          blk <= inv_mix(inv_core(blk) ^ rk[cnt]);
          cnt <= cnt - 4'd1;
        end
        FINAL:   data_out <= inv_core(blk) ^ rk[0];
        default: ;
      endcase
    end
  end

  // Round-key store carries no reset; validity lives in the cache flag
  always_ff @(posedge clk) begin
    if (accept && !hit)        rk[0]   <= key_in;
    else if (state == KEYEXP)  rk[cnt] <= key_step(rk[cnt - 4'd1], rcon(cnt));
  end
endmodule

// File: doc/aes_decrypt_ctrl.md
AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

Interface
REQ-001 Parameter: DOUT_RST, 128'h0, value of data_out after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 g_rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to decrypt; sampled only when ready=1.
REQ-005 key_in  input  128  AES-128 cipher key (FIPS-197 byte order, byte 0 = bits [127:120]); sampled with start.
REQ-006 data_in  input  128  ciphertext block; sampled with start.
REQ-007 ready  output  1  high in IDLE only; start accepted when start & ready.
REQ-008 data_out  output  128  plaintext; registered, updated only on completion.
REQ-009 done  output  1  one-cycle pulse, coincident with first cycle of new data_out.

Function
REQ-010 The block SHALL implement the FIPS-197 AES-128 inverse cipher, iterative, one round per clock.
REQ-011 States: IDLE, KEYEXP, INIT, ROUND, FINAL; one-hot or binary encoding is free.
REQ-012 IDLE: ready=1; on start=1, capture key_in and data_in, go to KEYEXP (or INIT, REQ-024).
REQ-013 KEYEXP: 10 cycles; cycle i (1..10) computes and stores round key rk[i] from rk[i-1] (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36); rk[0]=captured key; then go to INIT.
REQ-014 INIT: 1 cycle; state <= data ^ rk[10]; round counter <= 9; go to ROUND.
REQ-015 ROUND: per cycle state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[counter]); counter decrements; after counter=1 cycle go to FINAL (9 cycles).
REQ-016 FINAL: 1 cycle; data_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; done=1; go to IDLE.
REQ-017 Latency: done high 21 clocks after the accepting edge (no key reuse), 11 clocks with key reuse per REQ-024.
REQ-018 start while ready=0 SHALL be ignored; key_in/data_in changes mid-operation SHALL have no effect.
REQ-019 start high in the same cycle done pulses SHALL be ignored (ready=0 that cycle); accepted the following cycle.
REQ-020 data_out SHALL hold its value between completions; done SHALL never be high for two consecutive cycles.
REQ-021 Inverse S-box and forward S-box lookups SHALL be combinational; no multicycle paths.

Reset
REQ-022 On g_rst=1: state IDLE, ready=1, done=0, data_out=DOUT_RST, round counter=0, round-key store validity cleared; applies immediately regardless of clk.
REQ-023 g_rst asserted mid-operation SHALL abort it; no done pulse follows; first start after release runs full KEYEXP.

Configuration
REQ-024 Macro AES_DEC_KEY_CACHE_EN defined: block keeps the last expanded key plus a valid flag; start with key_in equal to cached key and valid=1 skips KEYEXP (IDLE -> INIT), latency 11; mismatch reruns KEYEXP and updates cache; valid set at end of KEYEXP.
REQ-025 Macro AES_DEC_KEY_CACHE_EN undefined: every accepted start runs KEYEXP; latency always 21; no comparator or valid flag in netlist.

Verification
REQ-026 Reset: assert g_rst asynchronously mid-cycle -> ready=1, done=0, data_out=128'h0 without a clock edge.
REQ-027 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff, done exactly 21 cycles after accept.
REQ-028 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-029 Busy handling: start pulsed and data_in changed at cycles 5 and 15 of REQ-027 run -> single done, result unchanged; start on done cycle ignored, next-cycle start accepted.
REQ-030 Abort: g_rst at cycle 12 of REQ-027 run -> no done; rerun after release gives REQ-027 result with 21-cycle latency.
REQ-031 With AES_DEC_KEY_CACHE_EN: REQ-027 twice back-to-back -> second done after 11 cycles; then REQ-028 key -> 21 cycles, correct plaintext.
